// File: rtl/mac_pkg.sv
// Shared definitions for the streaming multiply-accumulate block: width defaults,
// operand mode encoding and the per-term overflow detector.
package mac_pkg;

    localparam int A_W_DEF   = 8;
    localparam int B_W_DEF   = 8;
    localparam int ACC_W_DEF = 17;
    localparam int CNT_W_DEF = 8;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Overflow of acc + ext from the three MSBs alone: sign flip in signed mode,
    // carry out of the top bit in unsigned mode.
    function automatic logic term_ovf(input logic mode, input logic acc_msb,
                                      input logic ext_msb, input logic sum_msb);
        if (mode == MODE_SIGNED)
            return (acc_msb == ext_msb) && (sum_msb != acc_msb);
        return (acc_msb & ext_msb) | ((acc_msb | ext_msb) & ~sum_msb);
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Multiply stage P: registers the full-width product with its last/mode flags and
// owns the stall decision for the whole pipe.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     in_a,
    input  logic [B_W-1:0]     in_b,
    input  logic               in_last,
    input  logic               res_valid,
    input  logic               res_ready,
    output logic               vld_p0,
    output logic               last_p0,
    output logic               mode_p0,
    output logic [A_W+B_W-1:0] prod_p0,
    output logic               adv_p0
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] a_ext;
    logic [P_W-1:0] b_ext;
    logic [P_W-1:0] prod;
    logic           is_signed;

    // Extending both operands to the product width lets one multiplier serve both
    // modes: the low P_W bits of the product are exact either way.
    assign is_signed = (signed_mode == MODE_SIGNED);
    assign a_ext     = {{B_W{is_signed & in_a[A_W-1]}}, in_a};
    assign b_ext     = {{A_W{is_signed & in_b[B_W-1]}}, in_b};
    assign prod      = a_ext * b_ext;

    assign adv_p0   = vld_p0 && !(last_p0 && res_valid && !res_ready);
    assign in_ready = !clear && (!vld_p0 || adv_p0);

    // Stage P register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
            mode_p0 <= MODE_UNSIGNED;
            prod_p0 <= '0;
        end else if (clear) begin
            vld_p0 <= 1'b0;
        end else if (!vld_p0 || adv_p0) begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                prod_p0 <= prod;
                last_p0 <= in_last;
                mode_p0 <= signed_mode;
            end
        end
    end

endmodule

// File: rtl/mac_accum_stream.sv
// Streaming multiply-accumulate: frames of operand pairs in, one registered sum per
// frame out. Define MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_accum_stream
    import mac_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             signed_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_result,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam int P_W = A_W + B_W;

    generate
        if (ACC_W < P_W) begin : g_width_check
            $error("mac_accum_stream: ACC_W must be at least A_W+B_W");
        end
    endgenerate

    logic           vld_p0;
    logic           last_p0;
    logic           mode_p0;
    logic           adv_p0;
    logic [P_W-1:0] prod_p0;

    mac_mult_stage #(
        .A_W(A_W),
        .B_W(B_W)
    ) u_mult (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .res_valid  (out_valid),
        .res_ready  (out_ready),
        .vld_p0     (vld_p0),
        .last_p0    (last_p0),
        .mode_p0    (mode_p0),
        .prod_p0    (prod_p0),
        .adv_p0     (adv_p0)
    );

    function automatic logic [ACC_W-1:0] extend(input logic [P_W-1:0] p, input logic mode);
        logic [ACC_W-1:0] r;
        r          = {ACC_W{(mode == MODE_SIGNED) & p[P_W-1]}};
        r[P_W-1:0] = p;
        return r;
    endfunction

`ifdef MAC_SAT_EN
    // A signed overflow always moves toward the sign of the incoming term.
    function automatic logic [ACC_W-1:0] sat_value(input logic mode, input logic neg);
        if (mode == MODE_SIGNED)
            return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return {ACC_W{1'b1}};
    endfunction
`endif

    logic [ACC_W-1:0] acc_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             ovf_p1;
    logic [ACC_W-1:0] ext_p0;
    logic [ACC_W-1:0] sum_p0;
    logic [ACC_W-1:0] res_p0;
    logic [CNT_W-1:0] cnt_inc_p0;
    logic             term_ovf_p0;
    logic             load_p0;

    assign ext_p0      = extend(prod_p0, mode_p0);
    assign sum_p0      = acc_p1 + ext_p0;
    assign term_ovf_p0 = term_ovf(mode_p0, acc_p1[ACC_W-1], ext_p0[ACC_W-1], sum_p0[ACC_W-1]);
    assign cnt_inc_p0  = (cnt_p1 == {CNT_W{1'b1}}) ? cnt_p1 : cnt_p1 + CNT_W'(1);
    assign load_p0     = adv_p0 && last_p0 && !clear;

`ifdef MAC_SAT_EN
    assign res_p0 = term_ovf_p0 ? sat_value(mode_p0, ext_p0[ACC_W-1]) : sum_p0;
`else
    assign res_p0 = sum_p0;
`endif

    // Stage A: accumulator and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_p1     <= '0;
            cnt_p1     <= '0;
            ovf_p1     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else begin
            if (clear) begin
                acc_p1 <= '0;
                cnt_p1 <= '0;
                ovf_p1 <= 1'b0;
            end else if (adv_p0) begin
                if (last_p0) begin
                    acc_p1 <= '0;
                    cnt_p1 <= '0;
                    ovf_p1 <= 1'b0;
                end else begin
                    acc_p1 <= res_p0;
                    cnt_p1 <= cnt_inc_p0;
                    ovf_p1 <= ovf_p1 | term_ovf_p0;
                end
            end

            // A pending result survives clear; only a fresh load may replace it.
            if (load_p0) begin
                out_valid  <= 1'b1;
                out_result <= res_p0;
                out_count  <= cnt_inc_p0;
                out_ovf    <= ovf_p1 | term_ovf_p0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_accum_stream.sv
// Self-checking bench for mac_accum_stream: a scoreboard queue of expected frame
// results, drained by a monitor process forked from the main sequence.
module tb_mac_accum_stream;
    import mac_pkg::*;

    localparam int A_W   = 8;
    localparam int B_W   = 8;
    localparam int ACC_W = 17;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] res;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             signed_mode;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mac_accum_stream #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .signed_mode(signed_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    task automatic scoreboard_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got result=%0d count=%0d ovf=%0d, required no result",
                             out_result, out_count, out_ovf);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_result, out_count, out_ovf} !== e) begin
                        errors++;
                        $display("FAIL frame_result: got result=%0d count=%0d ovf=%0d, required result=%0d count=%0d ovf=%0d",
                                 out_result, out_count, out_ovf, e.res, e.cnt, e.ovf);
                    end
                end
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the pair.
    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic last, input logic mode);
        logic ok;
        int   n;
        n           = 0;
        in_a        = a;
        in_b        = b;
        in_last     = last;
        signed_mode = mode;
        in_valid    = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", n);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        clear       = 1'b0;
        signed_mode = MODE_UNSIGNED;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        #23;
        checks++;
        if ({out_valid, out_result, out_count, out_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b result=%0d count=%0d ovf=%0b, required all 0",
                     out_valid, out_result, out_count, out_ovf);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        out_ready = 1'b1;
        exp_q.push_back('{res: 17'd65067, cnt: 8'd3, ovf: 1'b0});
        send(8'd3, 8'd4, 1'b0, MODE_UNSIGNED);
        send(8'd5, 8'd6, 1'b0, MODE_UNSIGNED);
        send(8'd255, 8'd255, 1'b1, MODE_UNSIGNED);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%0b right after last accept, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_late: got out_valid=%0b one edge after last accept, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_signed();
        out_ready = 1'b1;
        exp_q.push_back('{res: 17'd16257, cnt: 8'd2, ovf: 1'b0});
        exp_q.push_back('{res: 17'h1FFFF, cnt: 8'd1, ovf: 1'b0});
        send(8'h80, 8'h80, 1'b0, MODE_SIGNED);
        send(8'd127, 8'hFF, 1'b1, MODE_SIGNED);
        send(8'hFF, 8'd1, 1'b1, MODE_SIGNED);
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
`ifdef MAC_SAT_EN
        exp_q.push_back('{res: 17'd131071, cnt: 8'd3, ovf: 1'b1});
        exp_q.push_back('{res: 17'h0FFFF, cnt: 8'd4, ovf: 1'b1});
`else
        exp_q.push_back('{res: 17'd64003, cnt: 8'd3, ovf: 1'b1});
        exp_q.push_back('{res: 17'h10000, cnt: 8'd4, ovf: 1'b1});
`endif
        exp_q.push_back('{res: 17'd1, cnt: 8'd1, ovf: 1'b0});
        for (int i = 0; i < 3; i++) send(8'd255, 8'd255, i == 2, MODE_UNSIGNED);
        for (int i = 0; i < 4; i++) send(8'h80, 8'h80, i == 3, MODE_SIGNED);
        send(8'd1, 8'd1, 1'b1, MODE_UNSIGNED);
        drain();
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        exp_q.push_back('{res: 17'd63, cnt: 8'd1, ovf: 1'b0});
        exp_q.push_back('{res: 17'd131057, cnt: 8'd1, ovf: 1'b0});
        send(8'd7, 8'd9, 1'b1, MODE_UNSIGNED);
        send(8'hFD, 8'd5, 1'b1, MODE_SIGNED);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %0b while stalled, required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 17'd63) begin
            errors++;
            $display("FAIL bp_hold: got valid=%0b result=%0d, required valid=1 result=63", out_valid, out_result);
        end
        checks++;
        if (exp_q.size() != 2) begin
            errors++;
            $display("FAIL bp_no_consume: got %0d queued, required 2", exp_q.size());
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 17'd131057) begin
            errors++;
            $display("FAIL bp_second_load: got valid=%0b result=%0d, required valid=1 result=131057",
                     out_valid, out_result);
        end
        drain();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_duplicate: got out_valid=%0b after both consumed, required 0", out_valid);
        end
    endtask

    task automatic test_clear();
        out_ready = 1'b0;
        exp_q.push_back('{res: 17'd16, cnt: 8'd1, ovf: 1'b0});
        send(8'd4, 8'd4, 1'b1, MODE_UNSIGNED);
        send(8'd10, 8'd10, 1'b0, MODE_UNSIGNED);
        send(8'd20, 8'd20, 1'b0, MODE_UNSIGNED);
        clear = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_ready: got %0b during clear, required 0", in_ready);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 17'd16) begin
            errors++;
            $display("FAIL clear_pending: got valid=%0b result=%0d, required valid=1 result=16", out_valid, out_result);
        end
        out_ready = 1'b1;
        exp_q.push_back('{res: 17'd6, cnt: 8'd1, ovf: 1'b0});
        send(8'd2, 8'd3, 1'b1, MODE_UNSIGNED);
        drain();
    endtask

    task automatic test_count_saturation();
        out_ready = 1'b1;
        exp_q.push_back('{res: 17'd300, cnt: 8'd255, ovf: 1'b0});
        for (int i = 0; i < 300; i++) send(8'd1, 8'd1, i == 299, MODE_UNSIGNED);
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send(8'd5, 8'd5, 1'b1, MODE_UNSIGNED);
        send(8'd1, 8'd1, 1'b0, MODE_UNSIGNED);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_result !== 17'd25) begin
            errors++;
            $display("FAIL pre_reset: got valid=%0b result=%0d, required valid=1 result=25", out_valid, out_result);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_result, out_count, out_ovf} !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b result=%0d count=%0d ovf=%0b, required all 0",
                     out_valid, out_result, out_count, out_ovf);
        end
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ready: got %0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back('{res: 17'd42, cnt: 8'd1, ovf: 1'b0});
        send(8'd6, 8'd7, 1'b1, MODE_UNSIGNED);
        drain();
    endtask

    task automatic test_random();
        logic [A_W-1:0]   ta[5];
        logic [B_W-1:0]   tb[5];
        logic             tm[5];
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] ext;
        logic [ACC_W-1:0] sum;
        logic             ovf;
        logic             t;
        int               cnt;
        int               n;
        int               prod;
        logic             done;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    n   = $urandom_range(1, 5);
                    acc = '0;
                    ovf = 1'b0;
                    cnt = 0;
                    for (int i = 0; i < n; i++) begin
                        ta[i] = A_W'($urandom);
                        tb[i] = B_W'($urandom);
                        tm[i] = 1'($urandom);
                        if (tm[i] == MODE_SIGNED) prod = int'($signed(ta[i])) * int'($signed(tb[i]));
                        else                      prod = int'(ta[i]) * int'(tb[i]);
                        ext = prod[ACC_W-1:0];
                        sum = acc + ext;
                        t   = term_ovf(tm[i], acc[ACC_W-1], ext[ACC_W-1], sum[ACC_W-1]);
`ifdef MAC_SAT_EN
                        if (t) sum = (tm[i] == MODE_SIGNED) ? (ext[ACC_W-1] ? 17'h10000 : 17'h0FFFF) : 17'h1FFFF;
`endif
                        acc = sum;
                        ovf = ovf | t;
                        cnt = (cnt < 255) ? cnt + 1 : 255;
                    end
                    exp_q.push_back('{res: acc, cnt: CNT_W'(cnt), ovf: ovf});
                    for (int i = 0; i < n; i++) send(ta[i], tb[i], i == n - 1, tm[i]);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_back_pressure();
        test_clear();
        test_count_saturation();
        test_random();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
